ta_rom_loader: RTL

Download write engine between the HPS `ioctl` stream and the Tropical Angel memory system, in the `clk_mem` domain. It captures byte writes of ROM index 0, buffers them in a small FIFO, and decodes each byte by ROM region. CPU and sound code go to SDRAM port 1 and sprite graphics go, remapped, to SDRAM port 2; both ports use toggle req/ack handshakes. Tile graphics and colour PROMs go to the on-chip `dl_*` bus. It replaces broadcasting every byte to both SDRAM ports, adding overflow detection and a completion flag.

---
 rtl/ta_rom_loader.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ta_rom_loader.sv
// ta_rom_loader: captures ROM-0 download bytes from the ioctl bus, queues them,
// and routes each byte by address region to SDRAM port 1, SDRAM port 2
// (sprite remap) or the on-chip dl_* write bus.
module ta_rom_loader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [16:0] SP_BASE    = 17'h10000
) (
  input  logic        clk_mem,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        dl_wr,
  output logic [16:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Region boundaries (exclusive upper bounds)
  localparam logic [16:0] P1_END   = 17'h0A000;
  localparam logic [16:0] SP_START = 17'h10000;
  localparam logic [16:0] SP_END   = 17'h1C000;
  localparam logic [16:0] PROM_END = 17'h1C320;

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE1,
    WAIT1,
    ISSUE2,
    WAIT2,
    LOCAL
  } state_t;

  typedef enum logic [1:0] {
    RG_PORT1,
    RG_PORT2,
    RG_LOCAL,
    RG_DROP
  } region_t;

  state_t           state;
  state_t           state_nxt;
  logic             wr_q;
  logic             download_q;
  logic             cap_c;
  logic             dl_rise_c;
  logic             push_c;
  logic             pop_c;
  logic             full_c;
  logic             empty_c;
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  entry_t           head;
  entry_t           cur;
  region_t          head_region;
  logic             seen;
  logic [15:0]      sp_off_c;

  assign cap_c     = ioctl_wr & ~wr_q & ioctl_download &
                     (ioctl_index == 8'd0) & (ioctl_addr[24:17] == 8'd0);
  assign dl_rise_c = ioctl_download & ~download_q;
  assign full_c    = (count == CNT_W'(FIFO_DEPTH));
  assign empty_c   = (count == '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte
  assign push_c    = cap_c & (~full_c | pop_c);
  assign head      = mem[rd_ptr];
  assign sp_off_c  = 16'(cur.addr - SP_BASE);

  // Edge-detect history for ioctl_wr and ioctl_download
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= 1'b0;
      download_q <= 1'b0;
    end else begin
      wr_q       <= ioctl_wr;
      download_q <= ioctl_download;
    end
  end

  // FIFO storage (data only, pointers carry validity)
  always_ff @(posedge clk_mem) begin
    if (push_c) begin
      mem[wr_ptr] <= '{addr: ioctl_addr[16:0], data: ioctl_dout};
    end
  end

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    case ({push_c, pop_c})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO pointers and count
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  // Classify the FIFO head by address region
  always_comb begin
    head_region = RG_DROP;
    if (head.addr < P1_END) begin
      head_region = RG_PORT1;
    end else if (head.addr < SP_START) begin
      head_region = RG_LOCAL;
    end else if (head.addr < SP_END) begin
      head_region = RG_PORT2;
    end else if (head.addr < PROM_END) begin
      head_region = RG_LOCAL;
    end
  end

  // State register
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and FIFO pop
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_c) begin
          pop_c = 1'b1;
          case (head_region)
            RG_PORT1: state_nxt = ISSUE1;
            RG_PORT2: state_nxt = ISSUE2;
            RG_LOCAL: state_nxt = LOCAL;
            default:  state_nxt = IDLE;
          endcase
        end
      end
      ISSUE1:  state_nxt = WAIT1;
      WAIT1:   if (port1_ack == port1_req) state_nxt = IDLE;
      ISSUE2:  state_nxt = WAIT2;
      WAIT2:   if (port2_ack == port2_req) state_nxt = IDLE;
      LOCAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Current-entry latch and the one-cycle local write strobe
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      cur     <= '0;
      dl_wr   <= 1'b0;
      dl_addr <= '0;
      dl_data <= '0;
    end else begin
      dl_wr <= 1'b0;
      if (pop_c) begin
        cur <= head;
        if (head_region == RG_LOCAL) begin
          dl_wr   <= 1'b1;
          dl_addr <= head.addr;
          dl_data <= head.data;
        end
      end
    end
  end

  // SDRAM port 1: byte lane picked by A[0], data replicated on both lanes
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      port1_req <= 1'b0;
      port1_a   <= '0;
      port1_ds  <= '0;
      port1_d   <= '0;
    end else if (state == ISSUE1) begin
      port1_req <= ~port1_req;
      port1_a   <= 23'(cur.addr[16:1]);
      port1_ds  <= {cur.addr[0], ~cur.addr[0]};
      port1_d   <= {cur.data, cur.data};
    end
  end

  // SDRAM port 2: sprite planes interleaved into 32-bit words
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      port2_req <= 1'b0;
      port2_a   <= '0;
      port2_ds  <= '0;
      port2_d   <= '0;
    end else if (state == ISSUE2) begin
      port2_req <= ~port2_req;
      port2_a   <= 23'({sp_off_c[13:0], sp_off_c[15]});
      port2_ds  <= {sp_off_c[14], ~sp_off_c[14]};
      port2_d   <= {cur.data, cur.data};
    end
  end

  // Status flags: busy, sticky overflow, download completion
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      overflow <= 1'b0;
      seen     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (count_nxt != '0) | (state_nxt != IDLE);

      if (cap_c & ~push_c) begin
        overflow <= 1'b1;
      end else if (dl_rise_c) begin
        overflow <= 1'b0;
      end

      if (cap_c) begin
        seen <= 1'b1;
      end else if (dl_rise_c) begin
        seen <= 1'b0;
      end

      if (dl_rise_c) begin
        done <= 1'b0;
      end else if (!ioctl_download && empty_c && (state == IDLE) && seen) begin
        done <= 1'b1;
      end
    end
  end

endmodule
